// File: rtl/calculate_pkg.sv
// Shared types and default constants for the calculate_pipe slice.
// Holds the FSM state encoding and the default OFFSET/THRESH values.
package calculate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam int signed OFFSET_DEFAULT = 100;
    localparam int signed THRESH_DEFAULT = 1000;

endpackage

// File: rtl/calculate_pipe_if.sv
// Handshake and operand/result bundle for calculate_pipe.
// master = requester side, slave = calculate_pipe side.
interface calculate_pipe_if #(
    parameter int DATA_W = 32
);

    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] ap_return;
    logic              ap_ovf;

    modport master (
        output ap_start, a, b,
        input  ap_ready, ap_done, ap_idle, ap_return, ap_ovf
    );

    modport slave (
        input  ap_start, a, b,
        output ap_ready, ap_done, ap_idle, ap_return, ap_ovf
    );

endinterface

// File: rtl/calculate_addsat.sv
// Combinational signed add with overflow flag and optional clamp to
// signed max/min when SAT_EN is set; wraps otherwise.
module calculate_addsat #(
    parameter int DATA_W = 32,
    parameter int SAT_EN = 0
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] raw;

    always_comb begin
        raw = x + y;
        ovf = (x[MSB] == y[MSB]) && (raw[MSB] != x[MSB]);
        sum = raw;
        // Operands share a sign on overflow, so x[MSB] gives its direction.
        if ((SAT_EN != 0) && ovf) begin
            sum = x[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/calculate_pipe.sv
// Four-state request pipeline: capture a/b, add OFFSET and compare against
// THRESH, then conditionally add b with overflow detection.
module calculate_pipe
    import calculate_pkg::*;
#(
    parameter int        DATA_W = 32,
    parameter int signed OFFSET = OFFSET_DEFAULT,
    parameter int signed THRESH = THRESH_DEFAULT,
    parameter int        SAT_EN = 0
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    calculate_pipe_if.slave  bus
);

    localparam logic        [DATA_W-1:0] OFFSET_C = DATA_W'(OFFSET);
    localparam logic signed [DATA_W-1:0] THRESH_C = DATA_W'(THRESH);

    state_t            state;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] value_r;
    logic              flag_r;
    logic [DATA_W-1:0] ret_r;
    logic              ovf_r;
    logic              done_r;

    logic [DATA_W-1:0] value_c;
    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;
    logic [DATA_W-1:0] res_c;
    logic              res_ovf_c;

    assign value_c = a_r + OFFSET_C;

    calculate_addsat #(
        .DATA_W (DATA_W),
        .SAT_EN (SAT_EN)
    ) u_addsat (
        .x   (value_r),
        .y   (b_r),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        res_c     = value_r;
        res_ovf_c = 1'b0;
        if (flag_r) begin
            res_c     = add_sum;
            res_ovf_c = add_ovf;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= ST_IDLE;
            ret_r  <= '0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ap_start) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    value_r <= value_c;
                    flag_r  <= $signed(value_c) > THRESH_C;
                    state   <= ST_ADD;
                end
                ST_ADD: begin
                    ret_r  <= res_c;
                    ovf_r  <= res_ovf_c;
                    done_r <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reset wins over ap_start, so no acceptance is advertised during reset.
    assign bus.ap_ready  = (state == ST_IDLE) && bus.ap_start && !ap_rst;
    assign bus.ap_idle   = (state == ST_IDLE);
    assign bus.ap_done   = done_r;
    assign bus.ap_return = ret_r;
    assign bus.ap_ovf    = ovf_r;

endmodule

// File: doc/calculate_pipe.md
CALCULATE_PIPE -- requirements
Module: calculate_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of a, b and ap_return.
REQ-002 SHALL have parameter OFFSET, default 100: signed constant added to a.
REQ-003 SHALL have parameter THRESH, default 1000: signed compare threshold.
REQ-004 SHALL have parameter SAT_EN, default 0: 1 = saturating conditional add, 0 = wrapping.
REQ-005 ap_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 ap_rst  in  1  synchronous, active-high reset.
REQ-007 ap_start  in  1  request; sampled only in IDLE.
REQ-008 ap_ready  out  1  high in the cycle a request is accepted (IDLE and ap_start).
REQ-009 ap_done  out  1  one-cycle pulse when ap_return holds a new result.
REQ-010 ap_idle  out  1  high only in IDLE.
REQ-011 a  in  DATA_W  signed operand, captured on acceptance.
REQ-012 b  in  DATA_W  signed operand, captured on acceptance.
REQ-013 ap_return  out  DATA_W  registered result, held until the next completion.
REQ-014 ap_ovf  out  1  registered; set when the conditional add overflowed, held with ap_return.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, ADD, DONE, with one transition per cycle: IDLE->CALC on ap_start, CALC->ADD, ADD->DONE, DONE->IDLE.
REQ-016 On acceptance, SHALL register a and b; later changes on a/b/ap_start SHALL NOT affect the result.
REQ-017 In CALC, SHALL register value = a_r + OFFSET, wrapping modulo 2^DATA_W.
REQ-018 In CALC, SHALL register flag = (signed value > signed THRESH), strictly greater.
REQ-019 In ADD, if flag = 1, SHALL compute value + b, else pass value unchanged with overflow = 0.
REQ-020 Signed overflow SHALL be detected when the operands share a sign and the sum sign differs.
REQ-021 If SAT_EN = 1 and overflow occurs, the result SHALL clamp to signed max (positive overflow) or signed min (negative overflow).
REQ-022 If SAT_EN = 0 and overflow occurs, the result SHALL wrap.
REQ-023 ap_ovf SHALL report overflow in both modes.
REQ-024 ap_return and ap_ovf SHALL update on the ADD->DONE edge; ap_done SHALL be high exactly in DONE.
REQ-025 Latency: ap_done SHALL be asserted 3 cycles after the acceptance cycle.
REQ-026 Throughput: one request per 4 cycles; ap_start held high SHALL be re-accepted at each IDLE.
REQ-027 ap_start outside IDLE SHALL be ignored, with no queuing.
REQ-028 ap_idle, ap_ready and ap_done SHALL be mutually exclusive except ap_idle with ap_ready in IDLE.

Reset
REQ-029 ap_rst SHALL force IDLE, ap_return = 0, ap_ovf = 0, ap_done = 0 on the next edge.
REQ-030 ap_rst SHALL take precedence over ap_start.
REQ-031 Reset in CALC, ADD or DONE SHALL abort the operation with no ap_done pulse and no result update.
REQ-032 The first request after reset deasserts SHALL be accepted normally.

Structure
REQ-033 Package calculate_pkg SHALL hold the state enum type and the default OFFSET/THRESH constants.
REQ-034 Sub-module calculate_addsat SHALL implement the DATA_W signed add with overflow flag and SAT_EN clamp (combinational).
REQ-035 The FSM and all registers SHALL reside in calculate_pipe; there SHALL be no latches and no async logic.

Verification
REQ-036 a=0, b=5 -> value 100, not > 1000; ap_return=100, ap_ovf=0, ap_done 3 cycles after ap_ready.
REQ-037 a=900, b=7 -> value 1000 (boundary, not greater) -> ap_return=1000; a=901, b=7 -> ap_return=1008.
REQ-038 a=2000, b=32'h7FFFFFFF -> SAT_EN=1: ap_return=32'h7FFFFFFF, ap_ovf=1; SAT_EN=0: ap_return=32'h80000833, ap_ovf=1.
REQ-039 a=32'h7FFFFFF0, b=5 -> value wraps to 32'h80000054 (negative) -> ap_return=32'h80000054, ap_ovf=0.
REQ-040 ap_start held high with 3 distinct operand sets -> ap_ready once per 4 cycles; results in order; ap_start pulses in CALC ignored.
REQ-041 ap_rst asserted in ADD -> next cycle IDLE, ap_idle=1, ap_return=0, no ap_done; next request completes correctly.
